// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two req/ready requesters.
// Optional macro MEM_ARB_LOCK_EN enables back-to-back locked grants (bounded by MAX_LOCK).
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_wstrb,
    input  logic              m0_lock,
    output logic              m0_ready,
    output logic [DW-1:0]     m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_wstrb,
    input  logic              m1_lock,
    output logic              m1_ready,
    output logic [DW-1:0]     m1_rdata,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_wstrb,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              win;
    logic              done_now;

`ifdef MEM_ARB_LOCK_EN
    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic              just_done_q, just_done_d;
    logic              lock_hit;
    logic              other_req;
    logic              locked;
`else
    logic              unused_lock;
    assign unused_lock = m0_lock | m1_lock;
`endif

    // An access completes on the write ACCESS cycle or on the RDATA cycle.
    assign done_now = ((state_q == ACCESS) && we_q) || (state_q == RDATA);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        win     = (m0_req && m1_req) ? ~last_q : m1_req;
`ifdef MEM_ARB_LOCK_EN
        lock_cnt_d  = lock_cnt_q;
        just_done_d = done_now;
        locked      = 1'b0;
        lock_hit    = just_done_q && (last_q ? (m1_lock && m1_req) : (m0_lock && m0_req));
        other_req   = last_q ? m0_req : m1_req;
        if (lock_hit && !((lock_cnt_q == LOCK_MAX) && other_req)) begin
            locked = 1'b1;
            win    = last_q;
        end
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                    gnt_d   = win;
                    last_d  = win;
                    we_d    = win ? m1_we    : m0_we;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    wstrb_d = win ? m1_wstrb : m0_wstrb;
`ifdef MEM_ARB_LOCK_EN
                    if (locked) begin
                        lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
                    end else begin
                        lock_cnt_d = '0;
                    end
`endif
                end
            end
            ACCESS:  state_d = we_q ? IDLE : RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
`ifdef MEM_ARB_LOCK_EN
            lock_cnt_q  <= '0;
            just_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
`ifdef MEM_ARB_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
            just_done_q <= just_done_d;
`endif
        end
    end

    // Handshake and write strobes are suppressed while reset is held, even mid-access.
    always_comb begin
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        mem_we    = 1'b0;
        mem_wstrb = '0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (!reset) begin
            m0_ready = done_now && !gnt_q;
            m1_ready = done_now && gnt_q;
            if (state_q == RDATA) begin
                if (gnt_q) m1_rdata = mem_rdata;
                else       m0_rdata = mem_rdata;
            end
            if (state_q == ACCESS) begin
                mem_we    = we_q;
                mem_wstrb = wstrb_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter and a behavioural memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        r_req[2];
    logic        r_we[2];
    logic [31:0] r_addr[2];
    logic [31:0] r_wdata[2];
    logic [3:0]  r_wstrb[2];
    logic        r_lock[2];

    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;

    assign m0_req = r_req[0];   assign m1_req = r_req[1];
    assign m0_we = r_we[0];     assign m1_we = r_we[1];
    assign m0_addr = r_addr[0]; assign m1_addr = r_addr[1];
    assign m0_wdata = r_wdata[0]; assign m1_wdata = r_wdata[1];
    assign m0_wstrb = r_wstrb[0]; assign m1_wstrb = r_wstrb[1];
    assign m0_lock = r_lock[0]; assign m1_lock = r_lock[1];

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_lock(m0_lock), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_lock(m1_lock), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port memory with one cycle of read latency
    logic [31:0] ram[64];
    logic [31:0] ref_mem[64];
    logic [31:0] merged;
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always_comb begin
        merged = ram[mem_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end

    always @(posedge clk) begin
        if (pre_en) ram[pre_idx] <= pre_val;
        else if (mem_we) ram[mem_addr[7:2]] <= merged;
        mem_rdata <= ram[mem_addr[7:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = val;
        ref_mem[idx] = val;
        step();
        pre_en = 1'b0;
    endtask

    task automatic set_req(input int k, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        r_req[k]   = 1'b1;
        r_we[k]    = we;
        r_addr[k]  = a;
        r_wdata[k] = d;
        r_wstrb[k] = s;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            r_req[k] = 1'b0; r_we[k] = 1'b0; r_addr[k] = '0;
            r_wdata[k] = '0; r_wstrb[k] = '0; r_lock[k] = 1'b0;
        end
        step();
        step();
        vectors++; if (m0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m0_ready got=%0b exp=0", m0_ready); end
        vectors++; if (m1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m1_ready got=%0b exp=0", m1_ready); end
        vectors++; if (m0_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_m0_rdata got=%h exp=0", m0_rdata); end
        vectors++; if (m1_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_m1_rdata got=%h exp=0", m1_rdata); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_we got=%0b exp=0", mem_we); end
        vectors++; if (mem_wstrb !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wstrb got=%h exp=0", mem_wstrb); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_contention();
        logic [31:0] exp_d;
        int w;
        preload(0, 32'h1111_0000);
        preload(1, 32'h2222_0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        r_lock[0] = 1'b1;
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int g = 0; g < 4; g++) begin
            w = g % 2;
            exp_d = (w == 0) ? 32'h1111_0000 : 32'h2222_0001;
            if (g > 0) step();
            step();
            vectors++; if ((m0_ready | m1_ready) !== 1'b0) begin miscompares++; $display("[TB] FAIL cont_access_ready g=%0d got=%0b%0b exp=00", g, m1_ready, m0_ready); end
            step();
            vectors++; if (m0_ready !== (w == 0)) begin miscompares++; $display("[TB] FAIL cont_m0_ready g=%0d got=%0b exp=%0b", g, m0_ready, w == 0); end
            vectors++; if (m1_ready !== (w == 1)) begin miscompares++; $display("[TB] FAIL cont_m1_ready g=%0d got=%0b exp=%0b", g, m1_ready, w == 1); end
            vectors++; if (((w == 0) ? m0_rdata : m1_rdata) !== exp_d) begin miscompares++; $display("[TB] FAIL cont_rdata g=%0d got=%h exp=%h", g, (w == 0) ? m0_rdata : m1_rdata, exp_d); end
            vectors++; if (((w == 0) ? m1_rdata : m0_rdata) !== 32'h0) begin miscompares++; $display("[TB] FAIL cont_other_rdata g=%0d got=%h exp=0", g, (w == 0) ? m1_rdata : m0_rdata); end
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        r_lock[0] = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        preload(4, 32'hDEAD_BEEF);
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        vectors++; if (m0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_early_ready got=%0b exp=0", m0_ready); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_access_we got=%0b exp=0", mem_we); end
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL rd_addr got=%h exp=10", mem_addr); end
        r_addr[0] = 32'h0;
        step();
        vectors++; if (m0_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ready got=%0b exp=1", m0_ready); end
        vectors++; if (m0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", m0_rdata); end
        vectors++; if (m1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_m1_ready got=%0b exp=0", m1_ready); end
        vectors++; if (m1_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rd_m1_rdata got=%h exp=0", m1_rdata); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_rdata_we got=%0b exp=0", mem_we); end
        r_req[0] = 1'b0;
        step();
        vectors++; if (m0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_ready_pulse got=%0b exp=0", m0_ready); end
    endtask

    task automatic test_single_write();
        set_req(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
        step();
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_we got=%0b exp=1", mem_we); end
        vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL wr_addr got=%h exp=20", mem_addr); end
        vectors++; if (mem_wdata !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL wr_wdata got=%h exp=12345678", mem_wdata); end
        vectors++; if (mem_wstrb !== 4'hF) begin miscompares++; $display("[TB] FAIL wr_wstrb got=%h exp=f", mem_wstrb); end
        vectors++; if (m1_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ready got=%0b exp=1", m1_ready); end
        vectors++; if (m0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_m0_ready got=%0b exp=0", m0_ready); end
        r_req[1] = 1'b0;
        step();
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_we_once got=%0b exp=0", mem_we); end
        vectors++; if (mem_wstrb !== 4'h0) begin miscompares++; $display("[TB] FAIL wr_wstrb_idle got=%h exp=0", mem_wstrb); end
        vectors++; if (m1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ready_once got=%0b exp=0", m1_ready); end
        set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        step();
        step();
        vectors++; if (m1_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_rb_ready got=%0b exp=1", m1_ready); end
        vectors++; if (m1_rdata !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL wr_rb_data got=%h exp=12345678", m1_rdata); end
        r_req[1] = 1'b0;
        step();
    endtask

    task automatic test_partial_strobe();
        preload(12, 32'h0);
        set_req(0, 1'b1, 32'h30, 32'hAABB_CCDD, 4'h2);
        step();
        vectors++; if (mem_wstrb !== 4'h2) begin miscompares++; $display("[TB] FAIL ps_wstrb got=%h exp=2", mem_wstrb); end
        r_req[0] = 1'b0;
        step();
        set_req(0, 1'b0, 32'h30, 32'h0, 4'h0);
        step();
        step();
        vectors++; if (m0_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ps_ready got=%0b exp=1", m0_ready); end
        vectors++; if (m0_rdata !== 32'h0000_CC00) begin miscompares++; $display("[TB] FAIL ps_data got=%h exp=0000cc00", m0_rdata); end
        r_req[0] = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_access();
        set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        step();
        reset = 1'b1;
        #1;
        vectors++; if (m1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rma_ready_in_rst got=%0b exp=0", m1_ready); end
        step();
        reset = 1'b0;
        r_req[1] = 1'b0;
        #1;
        vectors++; if (m1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rma_no_pulse got=%0b exp=0", m1_ready); end
        step();
        set_req(0, 1'b1, 32'h24, 32'h5A5A_5A5A, 4'hF);
        step();
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL rmw_we_pre got=%0b exp=1", mem_we); end
        reset = 1'b1;
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rmw_we_gated got=%0b exp=0", mem_we); end
        vectors++; if (m0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmw_ready_gated got=%0b exp=0", m0_ready); end
        r_req[0] = 1'b0;
        step();
        reset = 1'b0;
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        step();
        step();
        vectors++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rma_first_m0 got=%0b%0b exp=01", m1_ready, m0_ready); end
        vectors++; if (m0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rma_m0_data got=%h exp=deadbeef", m0_rdata); end
        r_req[0] = 1'b0;
        step();
        step();
        step();
        vectors++; if (m1_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rma_then_m1 got=%0b exp=1", m1_ready); end
        vectors++; if (m1_rdata !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL rma_m1_data got=%h exp=12345678", m1_rdata); end
        r_req[1] = 1'b0;
        step();
    endtask

    // Transaction-level model: one access at a time, round-robin on the last winner,
    // write done one cycle after grant, read done two cycles after grant.
    task automatic test_random();
        int          mlast, idle_from, done_c, gk, w, idx;
        bit          infl, gwe;
        bit          done_now[2];
        bit          granted[2];
        logic [31:0] gaddr, gwdata, gexp;
        logic [3:0]  gstrb;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mlast = 1; idle_from = 0; infl = 0; done_c = 0; gk = 0; gwe = 0;
        gaddr = '0; gwdata = '0; gexp = '0; gstrb = '0;
        granted[0] = 0; granted[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            done_now[0] = infl && (done_c == c) && (gk == 0);
            done_now[1] = infl && (done_c == c) && (gk == 1);
            vectors++; if (m0_ready !== done_now[0]) begin miscompares++; $display("[TB] FAIL rnd_m0_ready c=%0d got=%0b exp=%0b", c, m0_ready, done_now[0]); end
            vectors++; if (m1_ready !== done_now[1]) begin miscompares++; $display("[TB] FAIL rnd_m1_ready c=%0d got=%0b exp=%0b", c, m1_ready, done_now[1]); end
            vectors++; if (mem_we !== (infl && gwe && (done_c == c))) begin miscompares++; $display("[TB] FAIL rnd_mem_we c=%0d got=%0b exp=%0b", c, mem_we, infl && gwe && (done_c == c)); end
            if (infl && (done_c == c)) begin
                if (gwe) begin
                    vectors++; if (mem_addr !== gaddr || mem_wdata !== gwdata || mem_wstrb !== gstrb) begin
                        miscompares++;
                        $display("[TB] FAIL rnd_wr_fields c=%0d got=%h/%h/%h exp=%h/%h/%h", c, mem_addr, mem_wdata, mem_wstrb, gaddr, gwdata, gstrb);
                    end
                end else begin
                    vectors++; if (((gk == 0) ? m0_rdata : m1_rdata) !== gexp) begin miscompares++; $display("[TB] FAIL rnd_rdata c=%0d k=%0d got=%h exp=%h", c, gk, (gk == 0) ? m0_rdata : m1_rdata, gexp); end
                end
                vectors++; if (((gk == 0) ? m1_rdata : m0_rdata) !== 32'h0) begin miscompares++; $display("[TB] FAIL rnd_other_rdata c=%0d got=%h exp=0", c, (gk == 0) ? m1_rdata : m0_rdata); end
                infl = 0;
                granted[gk] = 0;
            end
            for (int k = 0; k < 2; k++) begin
                r_lock[k] = 1'($urandom_range(0, 1));
                if (done_now[k] || (!r_req[k] && !granted[k])) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                    else
                        r_req[k] = 1'b0;
                end else if (granted[k] && $urandom_range(0, 3) == 0) begin
                    r_we[k] = ~r_we[k];
                    r_addr[k] = $urandom;
                    r_wdata[k] = $urandom;
                    r_wstrb[k] = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 0) r_req[k] = 1'b0;
                end
            end
            if (!infl && c >= idle_from && (r_req[0] || r_req[1])) begin
                w = (r_req[0] && r_req[1]) ? 1 - mlast : (r_req[1] ? 1 : 0);
                mlast = w; gk = w; infl = 1; granted[w] = 1;
                gwe = r_we[w]; gaddr = r_addr[w]; gwdata = r_wdata[w]; gstrb = r_wstrb[w];
                idx = int'(gaddr[7:2]);
                done_c = c + (gwe ? 1 : 2);
                idle_from = c + (gwe ? 2 : 3);
                if (gwe) begin
                    for (int b = 0; b < 4; b++)
                        if (gstrb[b]) ref_mem[idx][8*b +: 8] = gwdata[8*b +: 8];
                end else begin
                    gexp = ref_mem[idx];
                end
            end
            step();
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_single_write();
        test_partial_strobe();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
